dmem_ctrl: RTL
==============

# dmem_ctrl

Memory-stage data-memory controller for the pipelined ARM core. It consumes the M-stage address and store data (`ALUOutM`, `WriteDataM`) and returns `ReadDataM` to the M/W pipeline register. It models a backing word RAM with a fixed multi-cycle access latency. While an access is in flight it raises `MemBusyM`, which the hazard unit uses to stall the whole pipeline.

## Interface
- `DEPTH`, default 256: number of 32-bit words; must be a power of two.
- `LAT`, default 2: access latency in cycles spent in ACCESS; minimum 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `MemReqM`  in  1: M-stage instruction is a load or store (`MemtoRegM | MemWriteM`).
- `MemWriteM`  in  1: 1 = store, 0 = load; valid with `MemReqM`.
- `ALUOutM`  in  32: byte address; bits [1:0] ignored.
- `WriteDataM`  in  32: store data.
- `ReadDataM`  out  32: load result; valid in the DONE cycle.
- `MemBusyM`  out  1: stall request to the hazard unit.
- `MemErrM`  out  1: out-of-range access flag (see Configuration).

## Operation
- Word index is `ALUOutM[log2(DEPTH)+1:2]`. Without range checking, higher address bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - `MemReqM=1`: latch address, write flag and data; load the counter with LAT-1; go to ACCESS.
  - `MemReqM=0`: stay in IDLE.
- **ACCESS**
  - Counter ≠ 0: decrement and stay.
  - Counter = 0: perform the RAM operation on this edge, then go to DONE.
  - Store: the write commits on this edge.
  - Load: the RAM word is captured into the `ReadDataM` register on this edge.
- **DONE**: go to IDLE unconditionally. The request still visible on the inputs during DONE is ignored and must not restart an access.
- `MemBusyM = (state==IDLE & MemReqM) | (state==ACCESS)`. This is combinational, so the stall begins in the request cycle.
- The pipeline advances the M instruction at the end of the first cycle with `MemBusyM=0` (the DONE cycle). Holding M beyond DONE by other means re-issues the access; the hazard unit must not do this.
- `ReadDataM` holds its last value until the next load completes. Stores leave it unchanged.
- Address, data and write flag are sampled only on the IDLE→ACCESS edge. Input changes during ACCESS are ignored.

## Timing
- A request arriving at cycle 0 in IDLE gives:
  - Busy high for cycles 0..LAT.
  - DONE at cycle LAT+1, with busy low and `ReadDataM` valid.
  - Total occupancy LAT+2 cycles; back-to-back requests are accepted every LAT+2 cycles.
- Reset values: state IDLE, counter 0, `ReadDataM`=0, `MemBusyM`=0, `MemErrM`=0. RAM contents are not reset.
- Reset asserted mid-ACCESS aborts the access. A store whose commit edge has not occurred is not written.
- Counter width is `$clog2(LAT)` (minimum 1 bit). There is no wrap, because the counter is reloaded on every entry to ACCESS.

## Configuration
- Controlled by macro `DMEM_RANGE_CHECK_EN`.
- **Defined**
  - Any of `ALUOutM[31:log2(DEPTH)+2]` nonzero at latch time marks the access out-of-range.
  - Out-of-range stores are dropped.
  - Out-of-range loads return `DMEM_ERR_WORD` (32'hDEADBEEF).
  - `MemErrM` is high in the DONE cycle of such an access, otherwise low.
  - The FSM timing is unchanged.
- **Undefined**: addresses wrap as above, and `MemErrM` is tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - the state enum `dmem_state_t` {IDLE, ACCESS, DONE};
  - `DMEM_ERR_WORD`;
  - the default LAT and DEPTH constants.
- Sub-module `dmem_ram`: single-port synchronous RAM with `we`, `addr`, `wd` and registered `rd`. `dmem_ctrl` owns the FSM, counter, latches and range check.

## Test plan
- **Reset:** hold `reset=0` with random inputs → `ReadDataM`=0, `MemBusyM`=0, `MemErrM`=0.
- **Store then load:**
  - LAT=2: store 32'h12345678 to 0x10 → `MemBusyM` high for cycles 0–2 and low at cycle 3.
  - Then load from 0x10 → `ReadDataM`=32'h12345678 in its DONE cycle.
- **Sticky request:** keep `MemReqM=1` with the same load through DONE → exactly one access; IDLE is re-entered, and a new access starts only on the following request cycle.
- **Reset mid-store:** store 32'hAAAA5555 to 0x20, pulse reset at cycle 1 → a later load from 0x20 returns the prior contents.
- **Address wrap:** DEPTH=256, no macro; store 32'hCAFEF00D to 0x400, load 0x000 → 32'hCAFEF00D.
- **Range check:** with `DMEM_RANGE_CHECK_EN` defined, load 0x400 → `ReadDataM`=32'hDEADBEEF and `MemErrM`=1 in DONE; word 0 is unchanged after a store to 0x400.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the M-stage data-memory
//               controller (FSM state encoding, error word, default sizes).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Controller sequencing: accept request, wait out latency, present result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  // Value returned by a load that falls outside the backing RAM.
  localparam logic [31:0] DMEM_ERR_WORD = 32'hDEADBEEF;

  // Default geometry and access latency.
  localparam int DMEM_DEFAULT_DEPTH = 256;
  localparam int DMEM_DEFAULT_LAT   = 2;

  // Width of the latency down-counter: enough to hold LAT-1, never zero bits.
  function automatic int dmem_cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port synchronous word RAM. Writes commit on the rising
//               edge when we_i is high; reads land in a registered output
//               that only updates when re_i is high, so the last load result
//               is held. Array contents are not reset; the read register is.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_q;

  // Storage array: write-only port, no reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wd_i;
    end
  end

  // Read data register: captures the addressed word only on a read strobe.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q <= 32'd0;
    end else if (re_i) begin
      rd_q <= mem_q[addr_i];
    end
  end

  assign rd_o = rd_q;

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : M-stage data-memory controller. Latches a load/store request,
//               holds the pipeline stalled (MemBusyM) for a fixed latency,
//               performs the RAM operation and presents the result in a
//               single DONE cycle.
//               Optional feature macro: DMEM_RANGE_CHECK_EN
//                 defined   - addresses beyond DEPTH words are flagged
//                             (MemErrM in DONE), stores dropped and loads
//                             return DMEM_ERR_WORD.
//                 undefined - addresses wrap modulo DEPTH, MemErrM is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEFAULT_DEPTH,
  parameter int LAT   = DMEM_DEFAULT_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM,
  output logic        MemErrM
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = dmem_cnt_width(LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [31:0]   wd_q;
  logic          oor_q;

  logic          start;
  logic          commit;
  logic          addr_oor;
  logic          ram_we;
  logic          ram_re;
  logic [31:0]   ram_rd;

  // A request is only accepted from IDLE; DONE deliberately ignores it.
  assign start  = (state_q == IDLE) && MemReqM;
  // The RAM operation happens on the last ACCESS edge.
  assign commit = (state_q == ACCESS) && (cnt_q == '0);

  // State and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch: address, direction, data and range flag frozen at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      wd_q   <= 32'd0;
      oor_q  <= 1'b0;
    end else if (start) begin
      addr_q <= ALUOutM[AW+1:2];
      we_q   <= MemWriteM;
      wd_q   <= WriteDataM;
      oor_q  <= addr_oor;
    end
  end

  // Out-of-range accesses never touch the RAM.
  assign ram_we = commit &&  we_q && !oor_q;
  assign ram_re = commit && !we_q && !oor_q;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n_i (reset),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (addr_q),
    .wd_i    (wd_q),
    .rd_o    (ram_rd)
  );

  // Stall from the request cycle through the last ACCESS cycle; held off
  // while reset is asserted so the pipeline is not frozen by stray inputs.
  assign MemBusyM = reset && (((state_q == IDLE) && MemReqM) || (state_q == ACCESS));

  // Byte-offset bits never select anything.
  logic unused_byte_offset;
  assign unused_byte_offset = ^ALUOutM[1:0];

`ifdef DMEM_RANGE_CHECK_EN
  logic rd_err_q;

  assign addr_oor = (ALUOutM >> (AW + 2)) != 32'd0;

  // Remembers whether the most recent completed load was out of range, so
  // ReadDataM keeps showing the error word until the next load completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_err_q <= 1'b0;
    end else if (commit && !we_q) begin
      rd_err_q <= oor_q;
    end
  end

  assign ReadDataM = rd_err_q ? DMEM_ERR_WORD : ram_rd;
  assign MemErrM   = (state_q == DONE) && oor_q;
`else
  logic unused_high_addr;

  assign addr_oor         = 1'b0;
  assign unused_high_addr = |(ALUOutM >> (AW + 2));
  assign ReadDataM        = ram_rd;
  assign MemErrM          = 1'b0;
`endif

endmodule : dmem_ctrl
`default_nettype wire
